// File: rtl/outmem_writeback_ctrl.sv
// Output write-back scheduler: quantizes PE accumulator vectors, queues them and writes
// them to the output SRAM, sharing the port with host reads. OUTMEM_SAT_EN selects saturating quantization.
module outmem_writeback_ctrl #(
  parameter int unsigned ACCU_WIDTH = 16,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH-1:0]            num_words,
  input  logic                             acc,
  input  logic [NUM_CH*ACCU_WIDTH-1:0]     obuf_write_data,
  input  logic                             host_req,
  input  logic [ADDR_WIDTH-1:0]            host_addr,
  output logic                             host_gnt,
  output logic                             host_rvalid,
  output logic [NUM_CH*OUT_WIDTH-1:0]      host_rdata,
  output logic                             mem_cen,
  output logic                             mem_wen,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [NUM_CH*OUT_WIDTH-1:0]      mem_d,
  input  logic [NUM_CH*OUT_WIDTH-1:0]      mem_q,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);
  localparam int unsigned WORD_W = NUM_CH * OUT_WIDTH;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SHIFT  = ACCU_WIDTH - OUT_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] base, nwords, wcount;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [WORD_W-1:0]     last_d;
  logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  pref_wr;
  logic                  wr_req, urgent, wr_gnt, cap, push, drop;
  logic [WORD_W-1:0]     q_word;

  // Per-channel quantization into the packed SRAM word
  for (genvar i = 0; i < NUM_CH; i++) begin : g_q
    logic [ACCU_WIDTH-1:0] a;
    assign a = obuf_write_data[i*ACCU_WIDTH +: ACCU_WIDTH];
`ifdef OUTMEM_SAT_EN
    logic [ACCU_WIDTH-1:0] sh;
    logic                  in_range;
    assign sh       = ACCU_WIDTH'($signed(a) >>> SHIFT);
    assign in_range = (&sh[ACCU_WIDTH-1:OUT_WIDTH-1]) || (~|sh[ACCU_WIDTH-1:OUT_WIDTH-1]);
    assign q_word[i*OUT_WIDTH +: OUT_WIDTH] = in_range ? sh[OUT_WIDTH-1:0]
        : {sh[ACCU_WIDTH-1], {(OUT_WIDTH-1){~sh[ACCU_WIDTH-1]}}};
`else
    logic unused_bits;
    assign q_word[i*OUT_WIDTH +: OUT_WIDTH] = {a[ACCU_WIDTH-1], a[SHIFT +: OUT_WIDTH-1]};
    assign unused_bits = ^{a[ACCU_WIDTH-2:SHIFT+OUT_WIDTH-1], a[SHIFT-1:0]};
`endif
  end

  assign host_rdata = mem_q;
  assign busy       = (state == S_ACTIVE);
  assign done       = (state == S_DONE);

  // Arbitration, port drive, capture decisions and next state
  always_comb begin
    state_nx = state;
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = last_addr;
    mem_d    = last_d;
    wr_req   = (state == S_ACTIVE) && enable && (count != '0) && !start;
    urgent   = (count >= CNT_W'(FIFO_DEPTH - 1));
    wr_gnt   = wr_req && (!host_req || urgent || pref_wr);
    host_gnt = host_req && !wr_gnt;
    if (wr_gnt) begin
      mem_cen  = 1'b0;
      mem_wen  = 1'b0;
      mem_addr = ADDR_WIDTH'(base + wcount);
      mem_d    = fifo_mem[rd_ptr];
    end else if (host_gnt) begin
      mem_cen  = 1'b0;
      mem_addr = host_addr;
    end
    cap  = (state == S_ACTIVE) && enable && acc && !start;
    push = cap && ((count != CNT_W'(FIFO_DEPTH)) || wr_gnt);
    drop = cap && (count == CNT_W'(FIFO_DEPTH)) && !wr_gnt;
    if (start) begin
      state_nx = (num_words == '0) ? S_DONE : S_ACTIVE;
    end else if (wr_gnt && (ADDR_WIDTH'(wcount + 1'b1) == nwords)) begin
      state_nx = S_DONE;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= q_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      base        <= '0;
      nwords      <= '0;
      wcount      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      pref_wr     <= 1'b0;
      host_rvalid <= 1'b0;
      last_addr   <= '0;
      last_d      <= '0;
    end else begin
      state       <= state_nx;
      host_rvalid <= host_gnt;
      if (wr_gnt || host_gnt) last_addr <= mem_addr;
      if (wr_gnt) last_d <= mem_d;
      // loser of a contested cycle is preferred next time
      if (wr_req && host_req) pref_wr <= host_gnt;
      if (start) begin
        base     <= base_addr;
        nwords   <= num_words;
        wcount   <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
        if (wr_gnt) begin
          rd_ptr <= PTR_W'(rd_ptr + 1'b1);
          wcount <= ADDR_WIDTH'(wcount + 1'b1);
        end
        count <= CNT_W'(count + CNT_W'(push) - CNT_W'(wr_gnt));
        if (drop) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_outmem_writeback_ctrl.sv
// Directed bench for outmem_writeback_ctrl: capture, quantization, arbitration, wrap and reset.
module tb_outmem_writeback_ctrl;
  logic         clk = 1'b0;
  logic         reset, enable, start, acc, host_req;
  logic [9:0]   base_addr, num_words, host_addr;
  logic [127:0] obuf_write_data;
  logic         host_gnt, host_rvalid, mem_cen, mem_wen, busy, done, overflow;
  logic [63:0]  host_rdata, mem_d, mem_q;
  logic [9:0]   mem_addr;
  int           tests = 0;
  int           failed = 0;
  int           n;
  logic [15:0]  exp_w;
  logic [63:0]  v2_exp;

  outmem_writeback_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .base_addr(base_addr), .num_words(num_words), .acc(acc),
    .obuf_write_data(obuf_write_data), .host_req(host_req), .host_addr(host_addr),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_q(mem_q), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] rep(input logic [15:0] c);
    return {8{c}};
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; acc = 1'b0; host_req = 1'b0;
    base_addr = '0; num_words = '0; host_addr = 10'h2AA;
    obuf_write_data = '0; mem_q = 64'hDEAD_BEEF_0123_4567;
`ifdef OUTMEM_SAT_EN
    v2_exp = 64'h807F7F7F7F7F7F24;
`else
    v2_exp = 64'h807E7E7E7E7E7E24;
`endif
    cyc();
    chk("rst_cen", mem_cen, 1); chk("rst_wen", mem_wen, 1);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0); chk("rst_gnt", host_gnt, 0);
    chk("rst_rvalid", host_rvalid, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_d", mem_d, 0);

    // single vector
    reset = 1'b0; enable = 1'b1;
    start = 1'b1; base_addr = 10'h040; num_words = 10'd1;
    cyc();
    start = 1'b0; acc = 1'b1; obuf_write_data = rep(16'h0380);
    #1 chk("sv_busy", busy, 1); chk("sv_nowr", mem_cen, 1);
    cyc();
    acc = 1'b0;
    #1 chk("sv_cen", mem_cen, 0); chk("sv_wen", mem_wen, 0);
    chk("sv_addr", mem_addr, 10'h040); chk("sv_d", mem_d, 64'h0707070707070707);
    chk("sv_done0", done, 0);
    cyc();
    chk("sv_done", done, 1); chk("sv_busy0", busy, 0); chk("sv_idle", mem_cen, 1);
    chk("sv_hold_a", mem_addr, 10'h040); chk("sv_hold_d", mem_d, 64'h0707070707070707);

    // address wrap and quantization corners
    start = 1'b1; base_addr = 10'h3FF; num_words = 10'd2;
    cyc();
    start = 1'b0; acc = 1'b1; obuf_write_data = rep(16'h0380);
    #1 chk("wr_nowr", mem_cen, 1);
    cyc();
    obuf_write_data = {16'h8000, {6{16'h7F00}}, 16'h1234};
    #1 chk("wr_a0", mem_addr, 10'h3FF); chk("wr_w0", mem_wen, 0);
    chk("wr_d0", mem_d, 64'h0707070707070707);
    cyc();
    acc = 1'b0;
    #1 chk("wr_a1", mem_addr, 10'h000); chk("wr_w1", mem_wen, 0); chk("wr_d1", mem_d, v2_exp);
    cyc();
    chk("wr_done", done, 1);

    // contention: alternating grants, host first
    start = 1'b1; base_addr = 10'h100; num_words = 10'd3;
    cyc();
    start = 1'b0; host_req = 1'b1; acc = 1'b1; obuf_write_data = rep(16'h0080);
    #1 chk("ct1_gnt", host_gnt, 1); chk("ct1_wen", mem_wen, 1);
    chk("ct1_cen", mem_cen, 0); chk("ct1_addr", mem_addr, 10'h2AA);
    cyc();
    obuf_write_data = rep(16'h0100);
    #1 chk("ct2_rv", host_rvalid, 1); chk("ct2_gnt", host_gnt, 1);
    chk("ct2_rdata", host_rdata, 64'hDEAD_BEEF_0123_4567);
    cyc();
    obuf_write_data = rep(16'h0180);
    #1 chk("ct3_rv", host_rvalid, 1); chk("ct3_gnt", host_gnt, 0);
    chk("ct3_wen", mem_wen, 0); chk("ct3_addr", mem_addr, 10'h100);
    chk("ct3_d", mem_d, 64'h0101010101010101);
    cyc();
    acc = 1'b0;
    #1 chk("ct4_rv", host_rvalid, 0); chk("ct4_gnt", host_gnt, 1);
    cyc();
    chk("ct5_rv", host_rvalid, 1); chk("ct5_addr", mem_addr, 10'h101);
    chk("ct5_d", mem_d, 64'h0202020202020202); chk("ct5_wen", mem_wen, 0);
    cyc();
    chk("ct6_gnt", host_gnt, 1);
    cyc();
    chk("ct7_addr", mem_addr, 10'h102); chk("ct7_d", mem_d, 64'h0303030303030303);
    chk("ct7_gnt", host_gnt, 0);
    cyc();
    chk("ct8_done", done, 1); chk("ct8_gnt", host_gnt, 1); chk("ct8_busy", busy, 0);
    cyc();
    host_req = 1'b0;
    #1 chk("ct9_rv", host_rvalid, 1);

    // six back-to-back vectors under host pressure: urgency prevents drops
    start = 1'b1; base_addr = 10'h200; num_words = 10'd6;
    cyc();
    start = 1'b0; host_req = 1'b1;
    n = 0; exp_w = 16'h0574;
    for (int c = 0; c < 16; c++) begin
      acc = (c < 6);
      obuf_write_data = rep(16'((c + 1) * 128));
      #1;
      chk("ov_gnt", host_gnt, !exp_w[c]);
      chk("ov_wen", mem_wen, !exp_w[c]);
      if (!mem_cen && !mem_wen) begin
        chk("ov_addr", mem_addr, 64'(32'h200 + n));
        chk("ov_data", mem_d, {8{8'(n + 1)}});
        n++;
      end
      cyc();
    end
    chk("ov_nwr", 64'(n), 6); chk("ov_flag", overflow, 0); chk("ov_done", done, 1);
    host_req = 1'b0;

    // enable low: acc ignored entirely
    start = 1'b1; base_addr = 10'h300; num_words = 10'd1;
    cyc();
    start = 1'b0; enable = 1'b0; acc = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("en_cen", mem_cen, 1); chk("en_busy", busy, 1);
      cyc();
    end
    enable = 1'b1; acc = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 chk("en_nowr", mem_cen, 1); chk("en_ovf", overflow, 0); chk("en_done", done, 0);
      cyc();
    end

    // zero word count completes immediately
    start = 1'b1; num_words = 10'd0;
    cyc();
    start = 1'b0;
    #1 chk("z_done", done, 1); chk("z_busy", busy, 0);

    // reset with two words queued
    start = 1'b1; base_addr = 10'h000; num_words = 10'd4;
    cyc();
    start = 1'b0; host_req = 1'b1; acc = 1'b1; obuf_write_data = rep(16'h0080);
    cyc();
    cyc();
    acc = 1'b0;
    #1 chk("rm_pre_gnt", host_gnt, 0); chk("rm_pre_wr", mem_wen, 0);
    host_req = 1'b0; reset = 1'b1;
    #1 chk("rm_cen", mem_cen, 1); chk("rm_busy", busy, 0); chk("rm_addr", mem_addr, 0);
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("rm_nowr", mem_cen, 1); chk("rm_busy2", busy, 0); chk("rm_done", done, 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/outmem_writeback_ctrl.md
# outmem_writeback_ctrl

Write-back scheduler between the PE array and the 64-bit output SRAM. Captures each accumulated output vector on `acc`, quantizes the eight 16-bit accumulators to eight 8-bit values and queues the packed word in a small FIFO. It then writes the queue to sequential SRAM addresses, sharing the single SRAM port with a host read requester. It tracks completion of a programmed word count and flags dropped vectors.

## Interface
- `ACCU_WIDTH`, 16, accumulator width per channel
- `NUM_CH`, 8, channels per `obuf_write_data` vector
- `OUT_WIDTH`, 8, quantized width per channel; SRAM word = `NUM_CH*OUT_WIDTH` = 64
- `ADDR_WIDTH`, 10, SRAM address width
- `FIFO_DEPTH`, 4, queued words (power of two, ≥2)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  write-side enable; gates capture, FIFO pop, counters and FSM
- `start`  in  1  one-cycle pulse: load `base_addr`/`num_words`, clear counters, flags and FIFO
- `base_addr`  in  `ADDR_WIDTH`  first write address
- `num_words`  in  `ADDR_WIDTH`  words to write before `done`
- `acc`  in  1  `obuf_write_data` valid this cycle
- `obuf_write_data`  in  `NUM_CH*ACCU_WIDTH`  channel i at `[i*16 +: 16]`
- `host_req`  in  1  host read request, held until granted
- `host_addr`  in  `ADDR_WIDTH`  host read address
- `host_gnt`  out  1  host owns the SRAM port this cycle
- `host_rvalid`  out  1  `host_rdata` valid; one cycle after `host_gnt`
- `host_rdata`  out  64  equals `mem_q`
- `mem_cen`  out  1  SRAM chip enable, active-low
- `mem_wen`  out  1  SRAM write enable, active-low
- `mem_addr`  out  `ADDR_WIDTH`  SRAM address
- `mem_d`  out  64  SRAM write data
- `mem_q`  in  64  SRAM read data, valid one cycle after a read access
- `busy`  out  1  state ACTIVE
- `done`  out  1  level; all `num_words` written
- `overflow`  out  1  sticky; at least one vector dropped since `start`

## Operation
- FSM has three states: IDLE → (`start`) ACTIVE → (writes == `num_words`) DONE → (`start`) ACTIVE. A `start` pulse in any state re-enters ACTIVE and flushes the FIFO.
- `start` with `num_words`=0 goes to DONE on the next edge.
- Capture happens in ACTIVE with `enable`=1 and `acc`=1. The quantized word is pushed.
  - Full FIFO with no pop the same cycle: the vector is dropped and `overflow` is set.
  - Full FIFO with a pop the same cycle: the vector is accepted.
- `acc` in IDLE or DONE is ignored. It does not set `overflow`.
- Quantization per channel i: `q_i = {a_i[15], a_i[13:7]}`, packed with channel 7 in bits `[63:56]` and channel 0 in `[7:0]`.
- Write address is `base_addr + wcount`, modulo 2^`ADDR_WIDTH` (wraps silently).
- Port arbitration is evaluated every cycle. A write contends only when ACTIVE, `enable`=1 and the FIFO is non-empty.
  - FIFO count ≥ `FIFO_DEPTH-1`: the write wins (urgent).
  - Only one contender: it wins.
  - Both contend and not urgent: the loser of the last contested cycle wins. Initial preference is host.
- Write grant drives `mem_cen`=0, `mem_wen`=0, `mem_addr`=write address, `mem_d`=FIFO head, then pops and increments `wcount`.
- Host grant drives `host_gnt`=1, `mem_cen`=0, `mem_wen`=1, `mem_addr`=`host_addr`. The host is served in every state, regardless of `enable`.
- With no grant, `mem_cen`=1, `mem_wen`=1, and `mem_addr`/`mem_d` hold their last values.

## Timing
- Reset values:
  - state IDLE.
  - `mem_cen`=1, `mem_wen`=1.
  - all other outputs 0; FIFO empty, counters 0.
- Port outputs are combinational from the arbiter. `host_rvalid` is registered.
- `acc` at cycle N → earliest SRAM write in cycle N+1 (empty FIFO, no host contention).
- Host grant at cycle N → `host_rvalid`=1 at N+1.
- `done` rises the cycle after the final write edge. `busy` falls on the same edge.
- Reset asserted mid-operation: everything returns to reset values immediately. FIFO contents are lost.

## Configuration
- `OUTMEM_SAT_EN` defined: per channel, arithmetic shift right by 7, then saturate to [-128, 127].
- `OUTMEM_SAT_EN` undefined: bit-select truncation as in Operation.

## Test plan
- Single vector:
  - Stimulus: `start` with `base_addr`=0x040, `num_words`=1; one `acc` with every channel = 0x0380.
  - Response: write next cycle at 0x040 with `mem_d`=0x0707070707070707; `done`=1 one cycle later.
- Contention:
  - Stimulus: `host_req` held continuously while 3 vectors are captured back-to-back.
  - Response: grants alternate (host first). Every host grant gives `host_rvalid` one cycle later. All 3 writes land at consecutive addresses.
- Overflow:
  - Stimulus: `host_req` held and 6 back-to-back `acc` with `FIFO_DEPTH`=4.
  - Response: urgency forces writes; no vector is dropped and `overflow`=0.
  - Stimulus (repeat): `enable`=0 while `acc` is forced high for 5 cycles.
  - Response: `acc` is ignored and `overflow`=0.
- Wrap: `base_addr`=0x3FF, `num_words`=2 → writes to 0x3FF then 0x000.
- Saturation (`OUTMEM_SAT_EN` defined): channel = 0x7F00 → 0x7F; channel = 0x8000 → 0x80. Undefined: 0x7F00 → 0x7E.
- Reset mid-run:
  - Stimulus: assert `reset` with 2 words queued.
  - Response: `mem_cen`=1 at once, `busy`=0, and no further writes after deassertion until `start`.
